pic_prog_loader: RTL and testbench

- Writable program store and boot loader for pic_core; replaces the fixed program ROM.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs into 12-bit instruction words.
- Validates the stream with an 8-bit two's-complement checksum.
- Serves instructions combinationally to the core's 9-bit program address. Asserts core_run only after a good load; the top level gates the core's reset with it.

---
 rtl/pic_pkg.sv | 25 ++
 rtl/pic_prog_loader_if.sv | 13 +
 rtl/pic_prog_ram.sv | 28 ++
 rtl/pic_prog_loader.sv | 102 ++++++++++
 tb/tb_pic_prog_loader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared constants and loader state encoding for the pic_core program store.
package pic_pkg;

  localparam int INST_W    = 12;
  localparam int PC_W      = 9;
  localparam int ROM_DEPTH = 512;
  localparam int CSUM_W    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_LO = 3'd1;
  localparam logic [2:0] ST_LOAD_HI = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LOAD_LO = ST_LOAD_LO,
    S_LOAD_HI = ST_LOAD_HI,
    S_CHECK   = ST_CHECK,
    S_RUN     = ST_RUN,
    S_ERROR   = ST_ERROR
  } ld_state_e;

endpackage

// File: rtl/pic_prog_loader_if.sv
// Byte-stream load port of the program loader.
// A byte transfers on a rising clock edge where ld_valid & ld_ready are both 1;
// while ld_valid=1 and ld_ready=0 the source holds ld_data and ld_last stable.
interface pic_prog_loader_if;
  logic       load_start;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_ready;
  logic       ld_last;

  modport master (output load_start, ld_data, ld_valid, ld_last, input ld_ready);
  modport slave  (input load_start, ld_data, ld_valid, ld_last, output ld_ready);
endinterface

// File: rtl/pic_prog_ram.sv
// Instruction store: synchronous write port, combinational read port.
module pic_prog_ram
  import pic_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = ROM_DEPTH
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [INST_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [INST_W-1:0] rd_data_o
);

  logic [INST_W-1:0] mem_q [DEPTH];

  // Contents deliberately survive reset so a core reset does not wipe the image.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_comb begin
    rd_data_o = '0;
    if ({1'b0, rd_addr_i} < (ADDR_W+1)'(DEPTH)) rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/pic_prog_loader.sv
// Boot loader: packs byte pairs into 12-bit words, verifies a two's-complement
// checksum and releases the core only after a good image.
module pic_prog_loader
  import pic_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = ROM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  pic_prog_loader_if.slave  ld,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [INST_W-1:0] rom_data,
  output logic              core_run,
  output logic              load_error,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        dbg_state
);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic [7:0]        lo_q;
  logic [ADDR_W:0]   wc_q;
  logic              run_q, err_q, busy_q;
  logic              in_load, xfer, last_addr, wr_en;

  assign in_load    = (state_q == S_LOAD_LO) || (state_q == S_LOAD_HI) || (state_q == S_CHECK);
  assign ld.ld_ready = in_load && !ld.load_start;
  assign xfer       = ld.ld_valid && ld.ld_ready;
  assign sum_d      = sum_q + ld.ld_data;
  assign last_addr  = (addr_q == ADDR_W'(DEPTH - 1));
  assign wr_en      = xfer && (state_q == S_LOAD_HI);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sum_q   <= '0;
      lo_q    <= '0;
      wc_q    <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ld.load_start) begin
      state_q <= S_LOAD_LO;
      addr_q  <= '0;
      sum_q   <= '0;
      wc_q    <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else if (xfer) begin
      case (state_q)
        S_LOAD_LO: begin
          lo_q    <= ld.ld_data;
          sum_q   <= sum_d;
          state_q <= S_LOAD_HI;
        end
        S_LOAD_HI: begin
          // The high nibble is discarded for storage but still counts in the sum.
          sum_q <= sum_d;
          wc_q  <= wc_q + 1'b1;
          if (ld.ld_last || last_addr) begin
            state_q <= S_CHECK;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= S_LOAD_LO;
          end
        end
        S_CHECK: begin
          busy_q <= 1'b0;
          if (sum_d == '0) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
          end else begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pic_prog_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clock     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (addr_q),
    .wr_data_i ({ld.ld_data[3:0], lo_q}),
    .rd_addr_i (rom_addr),
    .rd_data_o (rom_data)
  );

  assign core_run   = run_q;
  assign load_error = err_q;
  assign busy       = busy_q;
  assign word_count = wc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pic_prog_loader.sv
// Randomized bench for pic_prog_loader against a word-array/checksum reference model.
module tb_pic_prog_loader;
  import pic_pkg::*;

  logic        clock;
  logic        reset;
  logic [8:0]  rom_addr;
  logic [11:0] rom_data;
  logic        core_run, load_error, busy;
  logic [9:0]  word_count;
  logic [2:0]  dbg_state;

  pic_prog_loader_if lif ();

  pic_prog_loader dut (
    .clock      (clock),
    .reset      (reset),
    .ld         (lif),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .core_run   (core_run),
    .load_error (load_error),
    .busy       (busy),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model and scoreboard
  logic [11:0] model_mem [512];
  logic [7:0]  lo_b [512];
  logic [7:0]  hi_b [512];
  logic [11:0] exp_q [$];
  logic [7:0]  run_sum;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drivers
  task automatic send_byte(input logic [7:0] b, input logic last, input int max_gap);
    int  gap;
    bit  accepted;
    gap      = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    accepted = 1'b0;
    repeat (gap) begin
      lif.ld_valid = 1'b0;
      lif.ld_data  = 8'($urandom);
      @(posedge clock); #1;
    end
    lif.ld_valid = 1'b1;
    lif.ld_data  = b;
    lif.ld_last  = last;
    for (int t = 0; t < 64; t++) begin
      @(negedge clock);
      if (lif.ld_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    lif.ld_valid = 1'b0;
    lif.ld_last  = 1'b0;
    chk("handshake_accept", 32'(accepted), 32'd1);
  endtask

  task automatic pulse_start();
    lif.load_start = 1'b1;
    @(posedge clock); #1;
    lif.load_start = 1'b0;
    run_sum = 8'h00;
  endtask

  task automatic send_word(input int i, input logic last, input int max_gap);
    send_byte(lo_b[i], 1'b0, max_gap);
    send_byte(hi_b[i], last, max_gap);
    model_mem[i] = {hi_b[i][3:0], lo_b[i]};
    run_sum = run_sum + lo_b[i] + hi_b[i];
  endtask

  task automatic finish_load(input int n, input bit corrupt, input int max_gap);
    logic [7:0] c;
    c = 8'h00 - run_sum;
    if (corrupt) c = c ^ 8'h01;
    chk("state_check", 32'(dbg_state), 32'(ST_CHECK));
    chk("word_count_pre", 32'(word_count), 32'(n));
    send_byte(c, 1'b0, max_gap);
    chk("core_run", 32'(core_run), 32'(!corrupt));
    chk("load_error", 32'(load_error), 32'(corrupt));
    chk("busy_done", 32'(busy), 32'd0);
    chk("word_count", 32'(word_count), 32'(n));
  endtask

  task automatic load_image(input int n, input bit use_last, input int max_gap, input bit corrupt);
    pulse_start();
    for (int i = 0; i < n; i++) send_word(i, use_last && (i == n - 1), max_gap);
    finish_load(n, corrupt, max_gap);
  endtask

  task automatic readback(input string tag, input int n);
    for (int a = 0; a < n; a++) exp_q.push_back(model_mem[a]);
    for (int a = 0; a < n; a++) begin
      rom_addr = 9'(a);
      #1;
      chk(tag, 32'(rom_data), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    reset          = 1'b0;
    rom_addr       = '0;
    lif.load_start = 1'b0;
    lif.ld_data    = 8'h00;
    lif.ld_valid   = 1'b0;
    lif.ld_last    = 1'b0;
    run_sum        = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_ld_ready", 32'(lif.ld_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    @(negedge clock) reset = 1'b1;
    lif.ld_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_ld_ready", 32'(lif.ld_ready), 32'd0);
    chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("idle_core_run", 32'(core_run), 32'd0);
    lif.ld_valid = 1'b0;

    // Two-word image; checksum comes from the (sum + c) mod 256 == 0 rule
    lo_b[0] = 8'h25; hi_b[0] = 8'h0C; lo_b[1] = 8'h0A; hi_b[1] = 8'h08;
    load_image(2, 1'b1, 0, 1'b0);
    rom_addr = 9'd0; #1; chk("two_word_rd0", 32'(rom_data), 32'h0C25);
    rom_addr = 9'd1; #1; chk("two_word_rd1", 32'(rom_data), 32'h080A);

    // Bad checksum, then a good reload clears the error
    load_image(2, 1'b1, 0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("err_sticky", 32'(load_error), 32'd1);
    chk("err_no_run", 32'(core_run), 32'd0);
    load_image(2, 1'b1, 2, 1'b0);

    // Full image, no ld_last, random gaps
    for (int i = 0; i < 512; i++) begin
      lo_b[i] = 8'($urandom);
      hi_b[i] = 8'($urandom);
    end
    load_image(512, 1'b0, 3, 1'b0);
    readback("full_rd", 512);

    // load_start with a byte presented mid-stream
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      lo_b[i] = 8'($urandom);
      hi_b[i] = 8'($urandom);
      send_word(i, 1'b0, 1);
    end
    lif.ld_valid   = 1'b1;
    lif.ld_data    = 8'hA5;
    lif.load_start = 1'b1;
    @(negedge clock);
    chk("start_ld_ready", 32'(lif.ld_ready), 32'd0);
    @(posedge clock); #1;
    lif.load_start = 1'b0;
    lif.ld_valid   = 1'b0;
    run_sum        = 8'h00;
    chk("restart_wc", 32'(word_count), 32'd0);
    chk("restart_state", 32'(dbg_state), 32'(ST_LOAD_LO));
    chk("restart_busy", 32'(busy), 32'd1);
    lo_b[0] = 8'($urandom);
    hi_b[0] = 8'($urandom);
    send_word(0, 1'b1, 1);
    finish_load(1, 1'b0, 1);
    readback("restart_rd", 4);

    // Asynchronous reset in LOAD_HI
    pulse_start();
    send_byte(8'($urandom), 1'b0, 0);
    chk("pre_rst_state", 32'(dbg_state), 32'(ST_LOAD_HI));
    #2 reset = 1'b0;
    #1;
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("midrst_core_run", 32'(core_run), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ld_ready", 32'(lif.ld_ready), 32'd0);
    @(negedge clock) reset = 1'b1;

    // Short image, then sweep every address in RUN with junk on the stream
    for (int i = 0; i < 16; i++) begin
      lo_b[i] = 8'($urandom);
      hi_b[i] = 8'($urandom);
    end
    load_image(16, 1'b1, 1, 1'b0);
    lif.ld_valid = 1'b1;
    for (int a = 0; a < 512; a++) begin
      lif.ld_data = 8'($urandom);
      lif.ld_last = 1'($urandom);
      rom_addr    = 9'(a);
      @(negedge clock);
      chk("run_ld_ready", 32'(lif.ld_ready), 32'd0);
      chk("run_rd", 32'(rom_data), 32'(model_mem[a]));
      @(posedge clock); #1;
    end
    lif.ld_valid = 1'b0;
    lif.ld_last  = 1'b0;
    chk("run_hold", 32'(core_run), 32'd1);
    chk("run_wc", 32'(word_count), 32'd16);
    readback("post_sweep_rd", 512);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
